// File: rtl/gfx_color_wcombine.sv
// Write-combining pixel packer: merges pixels that hit one MEM_W-bit line into a
// line buffer with byte selects and issues one strobed line write per line.
module gfx_color_wcombine #(
    parameter int MEM_W   = 256,
    parameter int ADR_W   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               pix_valid_i,
    output logic               pix_ready_o,
    input  logic [ADR_W-1:0]   pix_adr_i,
    input  logic [31:0]        pix_color_i,
    input  logic [1:0]         color_depth_i,
    input  logic               flush_i,
    output logic               flush_done_o,
    output logic               straddle_o,
    output logic               mem_stb_o,
    input  logic               mem_ack_i,
    output logic [ADR_W-1:0]   mem_adr_o,
    output logic [MEM_W-1:0]   mem_dat_o,
    output logic [MEM_W/8-1:0] mem_sel_o,
    output logic               busy_o
);
    localparam int NB = MEM_W / 8;
    localparam int LB = $clog2(NB);
    localparam int TW = ADR_W - LB;
    localparam int CW = $clog2(TIMEOUT + 2);
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [LB:0]   LAST_B  = (LB+1)'(NB - 1);

    localparam logic [1:0] ST_EMPTY   = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_WRITE   = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             ready_q, ready_d;
    logic [TW-1:0]    tag_q, tag_d;
    logic [MEM_W-1:0] buf_dat_q, buf_dat_d;
    logic [NB-1:0]    buf_sel_q, buf_sel_d;
    logic             hold_vld_q, hold_vld_d;
    logic [TW-1:0]    hold_tag_q, hold_tag_d;
    logic [LB-1:0]    hold_off_q, hold_off_d;
    logic [31:0]      hold_color_q, hold_color_d;
    logic [1:0]       hold_depth_q, hold_depth_d;
    logic [CW-1:0]    idle_q, idle_d;
    logic             flush_pend_q, flush_pend_d;
    logic             flush_done_q, flush_done_d;
    logic             straddle_q, straddle_d;
    logic             stb_q, stb_d;
    logic [ADR_W-1:0] adr_q, adr_d;
    logic [MEM_W-1:0] dat_q, dat_d;
    logic [NB-1:0]    sel_q, sel_d;

    logic [LB-1:0]    pix_off;
    logic [TW-1:0]    pix_tag;
    logic             accept;
    logic             hit;
    logic             pix_straddle;
    logic             to_fire;

    assign pix_off      = pix_adr_i[LB-1:0];
    assign pix_tag      = pix_adr_i[ADR_W-1:LB];
    assign accept       = pix_valid_i & ready_q;
    assign hit          = (pix_tag == tag_q);
    assign pix_straddle = ({1'b0, pix_off} + (LB+1)'(color_depth_i)) > LAST_B;
    assign to_fire      = (TIMEOUT != 0) && (idle_q == TO_LAST);

    // One shared merge unit: the held pixel is replayed through it on a write ack,
    // otherwise the incoming pixel merges into the buffer (or a cleared buffer in EMPTY).
    logic [LB-1:0]    m_off;
    logic [31:0]      m_color;
    logic [1:0]       m_depth;
    logic [NB-1:0]    m_base_sel;
    logic [MEM_W-1:0] mrg_dat;
    logic [NB-1:0]    mrg_sel;

    assign m_off      = (state_q == ST_WRITE) ? hold_off_q   : pix_off;
    assign m_color    = (state_q == ST_WRITE) ? hold_color_q : pix_color_i;
    assign m_depth    = (state_q == ST_WRITE) ? hold_depth_q : color_depth_i;
    assign m_base_sel = (state_q == ST_COLLECT) ? buf_sel_q : '0;

    for (genvar gi = 0; gi < NB; gi++) begin : g_byte
        logic [LB-1:0] rel;
        logic          cov;
        assign rel = LB'(gi) - m_off;
        assign cov = (LB'(gi) >= m_off) && (rel <= LB'(m_depth));
        assign mrg_sel[gi]        = cov | m_base_sel[gi];
        assign mrg_dat[8*gi +: 8] = cov ? m_color[8*rel[1:0] +: 8] : buf_dat_q[8*gi +: 8];
    end

    logic             go_write;
    logic [MEM_W-1:0] wr_dat;
    logic [NB-1:0]    wr_sel;
    logic [TW-1:0]    wr_tag;
    logic             flush_req;

    always_comb begin
        state_d      = state_q;
        tag_d        = tag_q;
        buf_dat_d    = buf_dat_q;
        buf_sel_d    = buf_sel_q;
        hold_vld_d   = hold_vld_q;
        hold_tag_d   = hold_tag_q;
        hold_off_d   = hold_off_q;
        hold_color_d = hold_color_q;
        hold_depth_d = hold_depth_q;
        flush_pend_d = flush_pend_q;
        flush_done_d = 1'b0;
        straddle_d   = accept & pix_straddle;
        stb_d        = stb_q;
        adr_d        = adr_q;
        dat_d        = dat_q;
        sel_d        = sel_q;
        idle_d       = (idle_q != {CW{1'b1}}) ? idle_q + CW'(1) : idle_q;
        go_write     = 1'b0;
        wr_dat       = buf_dat_q;
        wr_sel       = buf_sel_q;
        wr_tag       = tag_q;
        flush_req    = flush_i | flush_pend_q;

        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    buf_dat_d = mrg_dat;
                    buf_sel_d = mrg_sel;
                    tag_d     = pix_tag;
                    state_d   = ST_COLLECT;
                    if (flush_i) begin
                        go_write     = 1'b1;
                        wr_dat       = mrg_dat;
                        wr_sel       = mrg_sel;
                        wr_tag       = pix_tag;
                        flush_pend_d = 1'b1;
                    end
                end else if (flush_i) begin
                    flush_done_d = 1'b1;
                end
            end
            ST_COLLECT: begin
                flush_pend_d = flush_req;
                if (accept && hit) begin
                    buf_dat_d = mrg_dat;
                    buf_sel_d = mrg_sel;
                    wr_dat    = mrg_dat;
                    wr_sel    = mrg_sel;
                    go_write  = flush_req;
                end else if (accept) begin
                    hold_vld_d   = 1'b1;
                    hold_tag_d   = pix_tag;
                    hold_off_d   = pix_off;
                    hold_color_d = pix_color_i;
                    hold_depth_d = color_depth_i;
                    go_write     = 1'b1;
                end else begin
                    go_write = flush_req | to_fire;
                end
            end
            ST_WRITE: begin
                flush_pend_d = flush_req;
                if (mem_ack_i) begin
                    stb_d = 1'b0;
                    sel_d = '0;
                    if (hold_vld_q) begin
                        buf_dat_d  = mrg_dat;
                        buf_sel_d  = mrg_sel;
                        tag_d      = hold_tag_q;
                        hold_vld_d = 1'b0;
                        state_d    = ST_COLLECT;
                    end else begin
                        flush_done_d = flush_req;
                        flush_pend_d = 1'b0;
                        state_d      = ST_EMPTY;
                    end
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        if (go_write) begin
            state_d = ST_WRITE;
            stb_d   = 1'b1;
            adr_d   = {wr_tag, {LB{1'b0}}};
            dat_d   = wr_dat;
            sel_d   = wr_sel;
        end
        if ((state_d != state_q) || accept) begin
            idle_d = '0;
        end
        ready_d = (state_d != ST_WRITE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_EMPTY;
            ready_q      <= 1'b1;
            tag_q        <= '0;
            buf_dat_q    <= '0;
            buf_sel_q    <= '0;
            hold_vld_q   <= 1'b0;
            hold_tag_q   <= '0;
            hold_off_q   <= '0;
            hold_color_q <= '0;
            hold_depth_q <= '0;
            idle_q       <= '0;
            flush_pend_q <= 1'b0;
            flush_done_q <= 1'b0;
            straddle_q   <= 1'b0;
            stb_q        <= 1'b0;
            adr_q        <= '0;
            dat_q        <= '0;
            sel_q        <= '0;
        end else begin
            state_q      <= state_d;
            ready_q      <= ready_d;
            tag_q        <= tag_d;
            buf_dat_q    <= buf_dat_d;
            buf_sel_q    <= buf_sel_d;
            hold_vld_q   <= hold_vld_d;
            hold_tag_q   <= hold_tag_d;
            hold_off_q   <= hold_off_d;
            hold_color_q <= hold_color_d;
            hold_depth_q <= hold_depth_d;
            idle_q       <= idle_d;
            flush_pend_q <= flush_pend_d;
            flush_done_q <= flush_done_d;
            straddle_q   <= straddle_d;
            stb_q        <= stb_d;
            adr_q        <= adr_d;
            dat_q        <= dat_d;
            sel_q        <= sel_d;
        end
    end

    assign pix_ready_o  = ready_q;
    assign flush_done_o = flush_done_q;
    assign straddle_o   = straddle_q;
    assign mem_stb_o    = stb_q;
    assign mem_adr_o    = adr_q;
    assign mem_dat_o    = dat_q;
    assign mem_sel_o    = sel_q;
    assign busy_o       = (state_q != ST_EMPTY);
endmodule
